fifo_singleclock_std: RTL and testbench
=======================================

FIFO_SINGLECLOCK_STD -- requirements
Module: fifo_singleclock_std

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, fill level at which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din  input  WIDTH  write data.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port full  output  1  no free entry.
REQ-009 SHALL have port almost_full  output  1  fill level >= AF_THRESH.
REQ-010 SHALL have port rd_en  input  1  read request (standard, non-FWFT read).
REQ-011 SHALL have port dout  output  WIDTH  registered read data.
REQ-012 SHALL have port empty  output  1  no stored entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse: write attempted while full.
REQ-015 SHALL have port underflow  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-016 SHALL accept a write iff wr_en && !full, storing din at wr_ptr and incrementing wr_ptr.
REQ-017 SHALL accept a read iff rd_en && !empty, loading mem[rd_ptr] into dout at that edge (1-cycle latency) and incrementing rd_ptr.
REQ-018 SHALL hold dout unchanged on every cycle without an accepted read.
REQ-019 SHALL keep wr_ptr/rd_ptr $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit and the lower bits address memory; pointers wrap modulo 2*DEPTH.
REQ-020 SHALL derive empty = (wr_ptr == rd_ptr) and full = (addresses equal, wrap bits differ), combinationally from registered pointers.
REQ-021 SHALL drive count = wr_ptr - rd_ptr, modulo 2*DEPTH.
REQ-022 SHALL evaluate full/empty on pre-edge state: at full with wr_en&&rd_en, only the read is accepted; at empty with wr_en&&rd_en, only the write is accepted.
REQ-023 SHALL, when neither full nor empty, accept simultaneous read and write, leaving count unchanged.
REQ-024 SHALL never return written data before the edge following its write (no write-to-read bypass).
REQ-025 SHALL pulse overflow for exactly one cycle after each cycle with wr_en && full, and underflow likewise for rd_en && empty; neither alters state.
REQ-026 SHALL ignore wr_en/rd_en while rst is low.

Reset
REQ-027 SHALL, on rst low, asynchronously clear wr_ptr, rd_ptr, dout, overflow and underflow to 0, giving empty=1, full=0, almost_full=0 (AF_THRESH>0), count=0.
REQ-028 SHALL not reset memory contents; no read may return them before a post-reset write.
REQ-029 SHALL discard all stored entries on reset asserted mid-operation.

Structure
REQ-030 SHALL keep pointer-width/count-width helper constants in shared package fifo_pkg, next to the existing FIFO helpers.
REQ-031 SHALL instantiate one sub-module, fifo_ram_sdp (simple dual-port RAM: one write port, one registered read port, no reset), holding storage and the dout register.
REQ-032 SHALL connect directly as the non-FWFT source of the FWFT conversion stage: dout/empty/rd_en map to fifo_dout/fifo_empty/fifo_rd_en.

Verification
REQ-033 SHALL cover: reset, write 0xA1,0xA2,0xA3 -> count 1,2,3; empty falls the cycle after the first write.
REQ-034 SHALL cover: three reads after REQ-033 -> dout 0xA1,0xA2,0xA3, each one cycle after its rd_en; empty=1 after the third; a fourth rd_en pulses underflow and dout stays 0xA3.
REQ-035 SHALL cover: DEPTH=16, write 16 words -> full=1, count=16, almost_full from count 14; a 17th write pulses overflow and is dropped.
REQ-036 SHALL cover: at full, wr_en&&rd_en -> read accepted, write dropped, count=15; at empty, both -> write accepted, dout unchanged, count=1.
REQ-037 SHALL cover: 40 streaming write/read pairs with DEPTH=16 -> pointers wrap twice, data order preserved, count stays 1.
REQ-038 SHALL cover: rst low mid-stream with count=7 -> count=0, empty=1, dout=0 immediately; first post-reset write/read returns the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helper package: pointer, address and count width helpers.
package fifo_pkg;

  // Address bits needed to index DEPTH entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width: address bits plus one wrap bit, so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Fill-level width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two (required for modulo pointer wrap).
  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// The storage array has no reset; only the read data register is cleared.
module fifo_ram_sdp
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write; contents survive reset and are never read before rewritten.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; holds its value on cycles without an accepted read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_singleclock_std.sv
// Single-clock standard (non-FWFT) FIFO. dout/empty/rd_en feed the FWFT
// conversion stage directly as fifo_dout/fifo_empty/fifo_rd_en.
module fifo_singleclock_std
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = addr_w(DEPTH);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_overflow, r_underflow;
  logic          w_full, w_empty, w_wr_acc, w_rd_acc;
  logic [PW-1:0] w_count;

  // Flags come straight from registered pointers, so they reflect pre-edge state.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]);
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // Pointer advance on accepted accesses; wraps modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Error pulses: one cycle after a rejected write or read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
    end
  end

  fifo_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (dout)
  );

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = w_count;
  assign almost_full = (w_count >= PW'(AF_THRESH));
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_singleclock_std.sv
// Bench for fifo_singleclock_std: directed scenarios then random traffic,
// all checked against a queue-based model of the FIFO.
module tb_fifo_singleclock_std;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             full, almost_full, empty, overflow, underflow;
  logic [WIDTH-1:0] dout;
  logic [4:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf = 1'b0, m_unf = 1'b0;

  fifo_singleclock_std #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  64'(count),       64'(q.size()));
    chk({tag, ".empty"},  64'(empty),       64'(q.size() == 0));
    chk({tag, ".full"},   64'(full),        64'(q.size() == DEPTH));
    chk({tag, ".afull"},  64'(almost_full), 64'(q.size() >= AFT));
    chk({tag, ".dout"},   64'(dout),        64'(m_dout));
    chk({tag, ".ovf"},    64'(overflow),    64'(m_ovf));
    chk({tag, ".unf"},    64'(underflow),   64'(m_unf));
  endtask

  // One clock: drive at negedge, model the edge, check 1 time unit after it.
  task automatic step(input string tag, input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    m_ovf = w && was_full;
    m_unf = r && was_empty;
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2 check_all("reset");
    @(negedge clk); rst = 1'b1;

    // Three writes then three reads, fourth read underflows
    step("wrA1", 1, 0, 32'hA1);
    step("wrA2", 1, 0, 32'hA2);
    step("wrA3", 1, 0, 32'hA3);
    step("rd1", 0, 1, '0);
    chk("rd1.val", 64'(dout), 64'hA1);
    step("rd2", 0, 1, '0);
    step("rd3", 0, 1, '0);
    chk("rd3.val", 64'(dout), 64'hA3);
    step("rd4", 0, 1, '0);
    chk("rd4.unf", 64'(underflow), 64'd1);
    step("idle", 0, 0, '0);

    // Fill to full, then one write too many
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 32'h100 + i);
    chk("fill.full", 64'(full), 64'd1);
    step("ovf", 1, 0, 32'hDEAD);
    chk("ovf.pulse", 64'(overflow), 64'd1);

    // Simultaneous access at full: only the read lands
    step("both_full", 1, 1, 32'hBEEF);
    chk("both_full.cnt", 64'(count), 64'd15);
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 1, '0);
    chk("drain.last", 64'(dout), 64'h10F);
    // Simultaneous access at empty: only the write lands, dout held
    step("both_empty", 1, 1, 32'hC0DE);
    chk("both_empty.cnt", 64'(count), 64'd1);

    // Streaming pairs, wrapping the pointers
    for (int i = 0; i < 40; i++) step("stream", 1, 1, 32'h2000 + i);
    chk("stream.cnt", 64'(count), 64'd1);

    // Build up to 7 entries, then reset mid-stream
    for (int i = 0; i < 6; i++) step("pre_rst", 1, 0, 32'h3000 + i);
    chk("pre_rst.cnt", 64'(count), 64'd7);
    @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    q.delete(); m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #1 check_all("mid_rst");
    @(negedge clk); rst = 1'b1;
    step("post_wr", 1, 0, 32'h5A5A5A5A);
    step("post_rd", 0, 1, '0);
    chk("post_rd.val", 64'(dout), 64'h5A5A5A5A);

    // Random traffic, biased so the FIFO visits both full and empty
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 2;
      step("rand", ($urandom_range(0, 3) > bias), ($urandom_range(0, 3) <= bias + 1), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
